inbuf_cmd_sequencer: RTL and testbench
======================================

Name: inbuf_cmd_sequencer

Overview:
- Sequences `inputbuffer_top` through one job at a time: LOAD (stream a picture into SRAM), ISSUE (sram2reg command handshake), DRAIN (let the OPU consume a fixed number of output beats).
- Jobs arrive in a small command FIFO.
- Sits between the APB register port / DMA source and `inputbuffer_top`, replacing per-step software pokes with hardware sequencing.

Parameters:
- IB_SRAM_AW, 10, input-buffer SRAM address width.
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- BEAT_CW, 16, width of the output-beat count field.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- cmd_push_i  in  1  push one job (ignored when full).
- cmd_waddr_i  in  IB_SRAM_AW  SRAM start write address.
- cmd_pic_size_i  in  8  rows to load, 1..255.
- cmd_mode_i  in  4  mode forwarded to the buffer.
- cmd_padding_i  in  1  padding enable forwarded.
- cmd_out_beats_i  in  BEAT_CW  opu1152 beats to drain, 1..2^BEAT_CW-1.
- cmd_full_o  out  1  FIFO full.
- cmd_level_o  out  $clog2(CMD_DEPTH)+1  FIFO occupancy.
- abort_i  in  1  synchronous flush.
- src_vld_i  in  1  source write-stream valid.
- src_hsync_i  in  1  last beat of a row.
- src_rdy_o  out  1  source ready.
- inbuf_din_vld_o  out  1  to buffer write_valid.
- inbuf_din_rdy_i  in  1  from buffer write_ready.
- inbuf_sop_o  out  1  first beat of a picture.
- inbuf_hsync_o  out  1  forwarded hsync.
- inbuf_start_waddr_o  out  IB_SRAM_AW  current job address.
- inbuf_pic_size_o  out  8  current job pic_size.
- inbuf_mode_o  out  4  current job mode.
- inbuf_padding_o  out  1  current job padding.
- inbuf_cmd_vld_o  out  1  sram2reg valid.
- inbuf_cmd_rdy_i  in  1  sram2reg ready.
- inbuf_dout_vld_i  in  1  opu1152 valid from buffer.
- opu_rdy_i  in  1  downstream consumer ready.
- inbuf_dout_rdy_o  out  1  opu1152 ready to buffer.
- opu_vld_o  out  1  gated valid to consumer.
- busy_o  out  1  state ≠ IDLE.
- job_done_o  out  1  one-cycle pulse at job end.
- err_o  out  1  sticky: push with pic_size==0 or out_beats==0 (push dropped); cleared by abort_i.

Behaviour:
- Reset: FSM=IDLE, FIFO empty, counters 0, all outputs 0 (config outputs 0).
- FIFO:
  - Push is accepted when `cmd_push_i && !full && fields valid`.
  - Pop occurs in the IDLE→LOAD cycle.
  - Simultaneous push and pop when full: the push is dropped (full is evaluated before the pop).
  - Level counts 0..CMD_DEPTH; pointers wrap modulo CMD_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, next cycle → LOAD. Job fields are latched into current-job registers, so config outputs change at LOAD entry and are stable for the whole job.
  - LOAD:
    - `inbuf_din_vld_o = src_vld_i`; `src_rdy_o = inbuf_din_rdy_i`; `inbuf_hsync_o = src_hsync_i`.
    - Outside LOAD all three are 0.
    - `inbuf_sop_o` is high with valid on the first beat only; it is cleared after the first handshake (handshake = vld&&rdy).
    - Row counter increments on each handshake with hsync.
    - When it reaches pic_size on that handshake → ISSUE next cycle.
  - ISSUE: `inbuf_cmd_vld_o = 1`, held until `inbuf_cmd_rdy_i`; on the handshake → DRAIN. Valid never drops before the handshake.
  - DRAIN:
    - `opu_vld_o = inbuf_dout_vld_i`; `inbuf_dout_rdy_o = opu_rdy_i`. Outside DRAIN both are 0.
    - Beat counter increments per handshake.
    - When it reaches out_beats → `job_done_o` pulse next cycle, state → IDLE.
- Throughput: IDLE costs exactly one bubble cycle between jobs; a queued job enters LOAD the cycle after `job_done_o`.
- abort_i (any state): next cycle FSM=IDLE, FIFO flushed, counters cleared, err_o cleared, no job_done_o. An abort coincident with a push: the push is dropped.
- Async reset mid-job: identical to reset; the buffer must also be reset by the same rst_n_i.
- Counter widths:
  - Row counter is 8 bits; compare happens before increment, so there is no wrap for pic_size ≤255.
  - Beat counter is BEAT_CW bits, same rule.

Decomposition:
- Package `inbuf_seq_pkg`:
  - FSM state enum (IDLE, LOAD, ISSUE, DRAIN, 2-bit).
  - Packed job struct (waddr, pic_size, mode, padding, out_beats) and its width constant.
- Sub-module `inbuf_cmd_fifo`: synchronous FIFO of the packed job word, with flush, full/empty/level.

Test Plan:
- Single job (waddr=0x040, pic_size=3, mode=2, padding=1, out_beats=5), source 4 beats/row, hsync on beat 4 → 12 din handshakes; sop only on beat 1; cmd_vld once; 5 dout handshakes; job_done_o one pulse; busy_o back to 0.
- Back-pressure: inbuf_din_rdy_i toggling 50%, inbuf_cmd_rdy_i delayed 7 cycles, opu_rdy_i random → cmd_vld held 8 cycles stable; counts unchanged; config outputs constant throughout the job.
- FIFO: push 5 jobs back-to-back with CMD_DEPTH=4 while IDLE → first pops after 1 cycle; 5th accepted only if it arrives after the pop, else dropped; level reads 4 when full; jobs executed in order.
- Illegal push pic_size=0, then out_beats=0 → both dropped, err_o=1, level=0; abort_i → err_o=0.
- abort_i in DRAIN after 2 of 5 beats with 2 jobs queued → IDLE next cycle; level=0; no job_done_o; next pushed job runs from a clean row/beat count.
- Async reset asserted mid-LOAD → all outputs 0 immediately; after release, busy_o=0 and a new job runs normally.

Source files
------------

// File: rtl/inbuf_seq_pkg.sv
// Shared types for the input-buffer job sequencer: FSM states and the packed job
// word that travels through the command FIFO.
package inbuf_seq_pkg;

    localparam int IB_AW  = 10;
    localparam int BEAT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [IB_AW-1:0]  waddr;
        logic [7:0]        pic_size;
        logic [3:0]        mode;
        logic              padding;
        logic [BEAT_W-1:0] out_beats;
    } job_t;

    localparam int JOB_W = $bits(job_t);

    // A zero row or beat count would never terminate the job, so such pushes are refused.
    function automatic logic job_fields_ok(input logic [7:0] pic_size,
                                           input logic [BEAT_W-1:0] out_beats);
        return (pic_size != 8'd0) && (out_beats != '0);
    endfunction

endpackage

// File: rtl/inbuf_cmd_fifo.sv
// Small synchronous FIFO for packed job words, with a synchronous flush.
// The head entry is visible combinationally so the sequencer can pop and latch in one cycle.
module inbuf_cmd_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Fullness is judged on the registered level, so a push into a full FIFO is lost
    // even when a pop happens in the same cycle.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/inbuf_cmd_sequencer.sv
// Runs queued jobs through the input buffer one at a time: stream the picture in (LOAD),
// hand over the sram2reg command (ISSUE), then let a fixed number of output beats pass (DRAIN).
module inbuf_cmd_sequencer
    import inbuf_seq_pkg::*;
#(
    parameter int  IB_SRAM_AW = IB_AW,
    parameter int  CMD_DEPTH  = 4,
    parameter int  BEAT_CW    = BEAT_W,
    localparam int LVL_W      = $clog2(CMD_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_push_i,
    input  logic [IB_SRAM_AW-1:0] cmd_waddr_i,
    input  logic [7:0]            cmd_pic_size_i,
    input  logic [3:0]            cmd_mode_i,
    input  logic                  cmd_padding_i,
    input  logic [BEAT_CW-1:0]    cmd_out_beats_i,
    output logic                  cmd_full_o,
    output logic [LVL_W-1:0]      cmd_level_o,
    input  logic                  abort_i,
    input  logic                  src_vld_i,
    input  logic                  src_hsync_i,
    output logic                  src_rdy_o,
    output logic                  inbuf_din_vld_o,
    input  logic                  inbuf_din_rdy_i,
    output logic                  inbuf_sop_o,
    output logic                  inbuf_hsync_o,
    output logic [IB_SRAM_AW-1:0] inbuf_start_waddr_o,
    output logic [7:0]            inbuf_pic_size_o,
    output logic [3:0]            inbuf_mode_o,
    output logic                  inbuf_padding_o,
    output logic                  inbuf_cmd_vld_o,
    input  logic                  inbuf_cmd_rdy_i,
    input  logic                  inbuf_dout_vld_i,
    input  logic                  opu_rdy_i,
    output logic                  inbuf_dout_rdy_o,
    output logic                  opu_vld_o,
    output logic                  busy_o,
    output logic                  job_done_o,
    output logic                  err_o
);

    seq_state_e         state_q, state_d;
    logic [7:0]         row_cnt_q, row_cnt_d;
    logic [BEAT_CW-1:0] beat_cnt_q, beat_cnt_d;
    logic               sop_pend_q, sop_pend_d;
    job_t               job_q, job_d;
    logic               job_done_q, job_done_d;
    logic               err_q, err_d;

    job_t               push_job;
    job_t               fifo_job;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               fields_ok;
    logic               push_ok;
    logic               din_hs;
    logic               dout_hs;
    logic [LVL_W-1:0]   fifo_level;

    always_comb begin
        push_job           = '0;
        push_job.waddr     = cmd_waddr_i;
        push_job.pic_size  = cmd_pic_size_i;
        push_job.mode      = cmd_mode_i;
        push_job.padding   = cmd_padding_i;
        push_job.out_beats = cmd_out_beats_i;
    end

    assign fields_ok = job_fields_ok(cmd_pic_size_i, cmd_out_beats_i);
    assign push_ok   = cmd_push_i && fields_ok && !abort_i;

    inbuf_cmd_fifo #(
        .W     (JOB_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (abort_i),
        .push_i  (push_ok),
        .pop_i   (fifo_pop),
        .din_i   (push_job),
        .dout_o  (fifo_job),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign din_hs  = (state_q == LOAD) && src_vld_i && inbuf_din_rdy_i;
    assign dout_hs = (state_q == DRAIN) && inbuf_dout_vld_i && opu_rdy_i;

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        beat_cnt_d = beat_cnt_q;
        sop_pend_d = sop_pend_q;
        job_d      = job_q;
        job_done_d = 1'b0;
        err_d      = err_q || (cmd_push_i && !fields_ok);
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    job_d      = fifo_job;
                    row_cnt_d  = '0;
                    beat_cnt_d = '0;
                    sop_pend_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (din_hs) begin
                    sop_pend_d = 1'b0;
                    if (src_hsync_i) begin
                        // Compare against pic_size-1 before incrementing so 255 rows never wrap.
                        row_cnt_d = row_cnt_q + 8'd1;
                        if (row_cnt_q == job_q.pic_size - 8'd1) begin
                            state_d = ISSUE;
                        end
                    end
                end
            end
            ISSUE: begin
                if (inbuf_cmd_rdy_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dout_hs) begin
                    beat_cnt_d = beat_cnt_q + BEAT_CW'(1);
                    if (beat_cnt_q == job_q.out_beats - BEAT_CW'(1)) begin
                        job_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a job completing in the same cycle.
        if (abort_i) begin
            state_d    = IDLE;
            row_cnt_d  = '0;
            beat_cnt_d = '0;
            sop_pend_d = 1'b0;
            job_done_d = 1'b0;
            err_d      = 1'b0;
            fifo_pop   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            beat_cnt_q <= '0;
            sop_pend_q <= 1'b0;
            job_q      <= '0;
            job_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            sop_pend_q <= sop_pend_d;
            job_q      <= job_d;
            job_done_q <= job_done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_full_o          = fifo_full;
    assign cmd_level_o         = fifo_level;

    assign inbuf_din_vld_o     = (state_q == LOAD) && src_vld_i;
    assign src_rdy_o           = (state_q == LOAD) && inbuf_din_rdy_i;
    assign inbuf_hsync_o       = (state_q == LOAD) && src_hsync_i;
    assign inbuf_sop_o         = (state_q == LOAD) && sop_pend_q && src_vld_i;

    assign inbuf_start_waddr_o = job_q.waddr;
    assign inbuf_pic_size_o    = job_q.pic_size;
    assign inbuf_mode_o        = job_q.mode;
    assign inbuf_padding_o     = job_q.padding;

    assign inbuf_cmd_vld_o     = (state_q == ISSUE);

    assign opu_vld_o           = (state_q == DRAIN) && inbuf_dout_vld_i;
    assign inbuf_dout_rdy_o    = (state_q == DRAIN) && opu_rdy_i;

    assign busy_o              = (state_q != IDLE);
    assign job_done_o          = job_done_q;
    assign err_o               = err_q;

endmodule

// File: tb/tb_inbuf_cmd_sequencer.sv
// Directed bench for inbuf_cmd_sequencer: one task per scenario, each comparing observed
// outputs against hand-computed values.
module tb_inbuf_cmd_sequencer;

    logic        clk_i;
    logic        rst_n_i;
    logic        cmd_push_i;
    logic [9:0]  cmd_waddr_i;
    logic [7:0]  cmd_pic_size_i;
    logic [3:0]  cmd_mode_i;
    logic        cmd_padding_i;
    logic [15:0] cmd_out_beats_i;
    logic        cmd_full_o;
    logic [2:0]  cmd_level_o;
    logic        abort_i;
    logic        src_vld_i;
    logic        src_hsync_i;
    logic        src_rdy_o;
    logic        inbuf_din_vld_o;
    logic        inbuf_din_rdy_i;
    logic        inbuf_sop_o;
    logic        inbuf_hsync_o;
    logic [9:0]  inbuf_start_waddr_o;
    logic [7:0]  inbuf_pic_size_o;
    logic [3:0]  inbuf_mode_o;
    logic        inbuf_padding_o;
    logic        inbuf_cmd_vld_o;
    logic        inbuf_cmd_rdy_i;
    logic        inbuf_dout_vld_i;
    logic        opu_rdy_i;
    logic        inbuf_dout_rdy_o;
    logic        opu_vld_o;
    logic        busy_o;
    logic        job_done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run_job call.
    int         r_din, r_sop_hs, r_sop_late, r_cmd_cyc, r_cmd_rise, r_dout, r_done, r_cfg_chg;
    bit         r_timeout;
    logic [9:0] r_waddr;
    logic [7:0] r_ps;
    logic [3:0] r_mode;
    logic       r_pad;

    inbuf_cmd_sequencer dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .cmd_push_i          (cmd_push_i),
        .cmd_waddr_i         (cmd_waddr_i),
        .cmd_pic_size_i      (cmd_pic_size_i),
        .cmd_mode_i          (cmd_mode_i),
        .cmd_padding_i       (cmd_padding_i),
        .cmd_out_beats_i     (cmd_out_beats_i),
        .cmd_full_o          (cmd_full_o),
        .cmd_level_o         (cmd_level_o),
        .abort_i             (abort_i),
        .src_vld_i           (src_vld_i),
        .src_hsync_i         (src_hsync_i),
        .src_rdy_o           (src_rdy_o),
        .inbuf_din_vld_o     (inbuf_din_vld_o),
        .inbuf_din_rdy_i     (inbuf_din_rdy_i),
        .inbuf_sop_o         (inbuf_sop_o),
        .inbuf_hsync_o       (inbuf_hsync_o),
        .inbuf_start_waddr_o (inbuf_start_waddr_o),
        .inbuf_pic_size_o    (inbuf_pic_size_o),
        .inbuf_mode_o        (inbuf_mode_o),
        .inbuf_padding_o     (inbuf_padding_o),
        .inbuf_cmd_vld_o     (inbuf_cmd_vld_o),
        .inbuf_cmd_rdy_i     (inbuf_cmd_rdy_i),
        .inbuf_dout_vld_i    (inbuf_dout_vld_i),
        .opu_rdy_i           (opu_rdy_i),
        .inbuf_dout_rdy_o    (inbuf_dout_rdy_o),
        .opu_vld_o           (opu_vld_o),
        .busy_o              (busy_o),
        .job_done_o          (job_done_o),
        .err_o               (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        cmd_push_i       = 1'b0;
        abort_i          = 1'b0;
        src_vld_i        = 1'b0;
        src_hsync_i      = 1'b0;
        inbuf_din_rdy_i  = 1'b0;
        inbuf_cmd_rdy_i  = 1'b0;
        inbuf_dout_vld_i = 1'b0;
        opu_rdy_i        = 1'b0;
    endtask

    task automatic do_push(input logic [9:0] wa, input logic [7:0] ps, input logic [3:0] md,
                           input logic pd, input logic [15:0] ob);
        cmd_waddr_i     = wa;
        cmd_pic_size_i  = ps;
        cmd_mode_i      = md;
        cmd_padding_i   = pd;
        cmd_out_beats_i = ob;
        cmd_push_i      = 1'b1;
        @(posedge clk_i);
        #1;
        cmd_push_i      = 1'b0;
    endtask

    // Drives source/command/sink sides of one job and records what it observed.
    task automatic run_job(input int bpr, input bit din_toggle, input int cmd_delay,
                           input bit opu_rand, input int stop_dout);
        int cyc;
        int bir;
        bit seen_busy;
        bit prev_cmd;
        bit done;
        cyc = 0; bir = 0; seen_busy = 0; prev_cmd = 0; done = 0;
        r_din = 0; r_sop_hs = 0; r_sop_late = 0; r_cmd_cyc = 0; r_cmd_rise = 0;
        r_dout = 0; r_done = 0; r_cfg_chg = 0; r_timeout = 0;
        r_waddr = '0; r_ps = '0; r_mode = '0; r_pad = 1'b0;
        while (!done && cyc < 600) begin
            if (stop_dout != 0 && r_dout == stop_dout) break;
            src_vld_i        = 1'b1;
            src_hsync_i      = (bir == bpr - 1);
            inbuf_din_rdy_i  = din_toggle ? (cyc % 2 == 1) : 1'b1;
            inbuf_cmd_rdy_i  = (r_cmd_cyc >= cmd_delay);
            inbuf_dout_vld_i = 1'b1;
            opu_rdy_i        = opu_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (busy_o) begin
                if (!seen_busy) begin
                    r_waddr = inbuf_start_waddr_o;
                    r_ps    = inbuf_pic_size_o;
                    r_mode  = inbuf_mode_o;
                    r_pad   = inbuf_padding_o;
                end else if (inbuf_start_waddr_o !== r_waddr || inbuf_pic_size_o !== r_ps ||
                             inbuf_mode_o !== r_mode || inbuf_padding_o !== r_pad) begin
                    r_cfg_chg++;
                end
                seen_busy = 1;
            end
            if (inbuf_din_vld_o && inbuf_din_rdy_i) begin
                if (inbuf_sop_o) begin
                    r_sop_hs++;
                    if (r_din != 0) r_sop_late++;
                end
                r_din++;
                bir = (bir == bpr - 1) ? 0 : bir + 1;
            end
            if (inbuf_cmd_vld_o) begin
                r_cmd_cyc++;
                if (!prev_cmd) r_cmd_rise++;
            end
            prev_cmd = inbuf_cmd_vld_o;
            if (opu_vld_o && inbuf_dout_rdy_o) r_dout++;
            if (job_done_o) begin
                r_done++;
                done = 1;
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        if (!done && !(stop_dout != 0 && r_dout == stop_dout)) r_timeout = 1;
        idle_inputs();
        $display("job waddr=%03h pic_size=%0d din_hs=%0d cmd_cycles=%0d dout_hs=%0d done=%0d",
                 r_waddr, r_ps, r_din, r_cmd_cyc, r_dout, r_done);
    endtask

    task automatic test_reset();
        idle_inputs();
        cmd_waddr_i = '0; cmd_pic_size_i = '0; cmd_mode_i = '0; cmd_padding_i = 1'b0;
        cmd_out_beats_i = '0;
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy got %0b exp 0", busy_o); end
        checks++; if (cmd_level_o !== 3'd0) begin errors++; $display("FAIL reset level got %0d exp 0", cmd_level_o); end
        checks++; if (cmd_full_o !== 1'b0) begin errors++; $display("FAIL reset full got %0b exp 0", cmd_full_o); end
        checks++; if ({inbuf_cmd_vld_o, job_done_o, err_o, inbuf_din_vld_o, opu_vld_o} !== 5'b0) begin
            errors++; $display("FAIL reset ctrl_outs got %05b exp 00000",
                               {inbuf_cmd_vld_o, job_done_o, err_o, inbuf_din_vld_o, opu_vld_o}); end
        checks++; if ({inbuf_start_waddr_o, inbuf_pic_size_o, inbuf_mode_o, inbuf_padding_o} !== 23'd0) begin
            errors++; $display("FAIL reset config got %06h exp 0",
                               {inbuf_start_waddr_o, inbuf_pic_size_o, inbuf_mode_o, inbuf_padding_o}); end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_single_job();
        do_push(10'h040, 8'd3, 4'd2, 1'b1, 16'd5);
        run_job(4, 1'b0, 0, 1'b0, 0);
        checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL single timeout got 1 exp 0"); end
        checks++; if (r_din !== 12) begin errors++; $display("FAIL single din_hs got %0d exp 12", r_din); end
        checks++; if (r_sop_hs !== 1 || r_sop_late !== 0) begin errors++; $display("FAIL single sop got %0d/%0d exp 1/0", r_sop_hs, r_sop_late); end
        checks++; if (r_cmd_rise !== 1 || r_cmd_cyc !== 1) begin errors++; $display("FAIL single cmd_vld got %0d/%0d exp 1/1", r_cmd_rise, r_cmd_cyc); end
        checks++; if (r_dout !== 5) begin errors++; $display("FAIL single dout_hs got %0d exp 5", r_dout); end
        checks++; if (r_done !== 1) begin errors++; $display("FAIL single job_done got %0d exp 1", r_done); end
        checks++; if ({r_waddr, r_ps, r_mode, r_pad} !== {10'h040, 8'd3, 4'd2, 1'b1}) begin
            errors++; $display("FAIL single config got %03h/%0d/%0d/%0b exp 040/3/2/1", r_waddr, r_ps, r_mode, r_pad); end
        checks++; if (job_done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL single after_done got done=%0b busy=%0b exp 0/0", job_done_o, busy_o); end
    endtask

    task automatic test_back_pressure();
        do_push(10'h155, 8'd3, 4'd9, 1'b0, 16'd5);
        run_job(4, 1'b1, 7, 1'b1, 0);
        checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL bp timeout got 1 exp 0"); end
        checks++; if (r_din !== 12) begin errors++; $display("FAIL bp din_hs got %0d exp 12", r_din); end
        checks++; if (r_sop_hs !== 1 || r_sop_late !== 0) begin errors++; $display("FAIL bp sop got %0d/%0d exp 1/0", r_sop_hs, r_sop_late); end
        checks++; if (r_cmd_cyc !== 8) begin errors++; $display("FAIL bp cmd_vld_cycles got %0d exp 8", r_cmd_cyc); end
        checks++; if (r_cmd_rise !== 1) begin errors++; $display("FAIL bp cmd_vld_rises got %0d exp 1", r_cmd_rise); end
        checks++; if (r_dout !== 5) begin errors++; $display("FAIL bp dout_hs got %0d exp 5", r_dout); end
        checks++; if (r_done !== 1) begin errors++; $display("FAIL bp job_done got %0d exp 1", r_done); end
        checks++; if (r_cfg_chg !== 0) begin errors++; $display("FAIL bp config_changes got %0d exp 0", r_cfg_chg); end
        checks++; if ({r_waddr, r_ps, r_mode, r_pad} !== {10'h155, 8'd3, 4'd9, 1'b0}) begin
            errors++; $display("FAIL bp config got %03h/%0d/%0d/%0b exp 155/3/9/0", r_waddr, r_ps, r_mode, r_pad); end
    endtask

    task automatic test_fifo();
        int exp_lvl [5] = '{1, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            do_push(10'(10'h100 + i), 8'd1, 4'(i), 1'b0, 16'd1);
            checks++; if (cmd_level_o !== 3'(exp_lvl[i])) begin
                errors++; $display("FAIL fifo level_after_push%0d got %0d exp %0d", i, cmd_level_o, exp_lvl[i]); end
        end
        checks++; if (cmd_full_o !== 1'b1) begin errors++; $display("FAIL fifo full got %0b exp 1", cmd_full_o); end
        do_push(10'h1FF, 8'd1, 4'd0, 1'b0, 16'd1);
        checks++; if (cmd_level_o !== 3'd4) begin errors++; $display("FAIL fifo push_when_full level got %0d exp 4", cmd_level_o); end
        for (int i = 0; i < 5; i++) begin
            run_job(1, 1'b0, 0, 1'b0, 0);
            checks++; if (r_done !== 1 || r_din !== 1 || r_dout !== 1) begin
                errors++; $display("FAIL fifo job%0d counts got %0d/%0d/%0d exp 1/1/1", i, r_done, r_din, r_dout); end
            checks++; if (r_waddr !== 10'(10'h100 + i)) begin
                errors++; $display("FAIL fifo job%0d order got %03h exp %03h", i, r_waddr, 10'h100 + i); end
            checks++; if (busy_o !== (i < 4)) begin
                errors++; $display("FAIL fifo job%0d next_load busy got %0b exp %0b", i, busy_o, i < 4); end
        end
        checks++; if (cmd_level_o !== 3'd0) begin errors++; $display("FAIL fifo final level got %0d exp 0", cmd_level_o); end
    endtask

    task automatic test_illegal_push();
        do_push(10'h010, 8'd0, 4'd1, 1'b0, 16'd5);
        checks++; if (err_o !== 1'b1 || cmd_level_o !== 3'd0) begin
            errors++; $display("FAIL illegal ps0 got err=%0b level=%0d exp 1/0", err_o, cmd_level_o); end
        do_push(10'h010, 8'd2, 4'd1, 1'b0, 16'd0);
        checks++; if (err_o !== 1'b1 || cmd_level_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL illegal beats0 got err=%0b level=%0d busy=%0b exp 1/0/0", err_o, cmd_level_o, busy_o); end
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL illegal err_after_abort got %0b exp 0", err_o); end
    endtask

    task automatic test_abort();
        do_push(10'h200, 8'd1, 4'd3, 1'b1, 16'd5);
        do_push(10'h201, 8'd1, 4'd3, 1'b1, 16'd5);
        do_push(10'h202, 8'd1, 4'd3, 1'b1, 16'd5);
        checks++; if (cmd_level_o !== 3'd2) begin errors++; $display("FAIL abort queued level got %0d exp 2", cmd_level_o); end
        run_job(2, 1'b0, 0, 1'b0, 2);
        checks++; if (r_dout !== 2 || r_done !== 0 || r_timeout !== 1'b0) begin
            errors++; $display("FAIL abort pre_abort got dout=%0d done=%0d to=%0b exp 2/0/0", r_dout, r_done, r_timeout); end
        // Abort together with a legal push: the push must be lost with the rest of the queue.
        cmd_waddr_i = 10'h3FF; cmd_pic_size_i = 8'd1; cmd_out_beats_i = 16'd1;
        cmd_push_i = 1'b1;
        abort_i = 1'b1;
        inbuf_dout_vld_i = 1'b1;
        opu_rdy_i = 1'b1;
        @(posedge clk_i);
        #1;
        idle_inputs();
        checks++; if (busy_o !== 1'b0 || cmd_level_o !== 3'd0) begin
            errors++; $display("FAIL abort state got busy=%0b level=%0d exp 0/0", busy_o, cmd_level_o); end
        checks++; if (job_done_o !== 1'b0) begin errors++; $display("FAIL abort done_pulse got %0b exp 0", job_done_o); end
        @(posedge clk_i);
        #1;
        checks++; if (job_done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL abort settled got done=%0b busy=%0b exp 0/0", job_done_o, busy_o); end
        do_push(10'h2A0, 8'd2, 4'd5, 1'b0, 16'd3);
        run_job(3, 1'b0, 0, 1'b0, 0);
        checks++; if (r_din !== 6 || r_dout !== 3 || r_done !== 1 || r_sop_hs !== 1) begin
            errors++; $display("FAIL abort next_job got din=%0d dout=%0d done=%0d sop=%0d exp 6/3/1/1", r_din, r_dout, r_done, r_sop_hs); end
        checks++; if (r_waddr !== 10'h2A0) begin errors++; $display("FAIL abort next_job waddr got %03h exp 2a0", r_waddr); end
    endtask

    task automatic test_async_reset();
        do_push(10'h0C0, 8'd3, 4'd7, 1'b1, 16'd5);
        src_vld_i = 1'b1;
        inbuf_din_rdy_i = 1'b1;
        src_hsync_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++; if (busy_o !== 1'b1 || inbuf_sop_o !== 1'b1) begin
            errors++; $display("FAIL areset load_entry got busy=%0b sop=%0b exp 1/1", busy_o, inbuf_sop_o); end
        @(posedge clk_i);
        #1;
        checks++; if (inbuf_din_vld_o !== 1'b1 || inbuf_sop_o !== 1'b0) begin
            errors++; $display("FAIL areset second_beat got vld=%0b sop=%0b exp 1/0", inbuf_din_vld_o, inbuf_sop_o); end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++; if ({busy_o, inbuf_din_vld_o, src_rdy_o, inbuf_sop_o, inbuf_cmd_vld_o, opu_vld_o,
                       inbuf_dout_rdy_o, job_done_o, err_o} !== 9'b0) begin
            errors++; $display("FAIL areset outputs got %09b exp 0", {busy_o, inbuf_din_vld_o, src_rdy_o,
                               inbuf_sop_o, inbuf_cmd_vld_o, opu_vld_o, inbuf_dout_rdy_o, job_done_o, err_o}); end
        checks++; if (inbuf_start_waddr_o !== 10'd0 || inbuf_pic_size_o !== 8'd0 || inbuf_mode_o !== 4'd0) begin
            errors++; $display("FAIL areset config got %03h/%0d/%0d exp 0/0/0", inbuf_start_waddr_o, inbuf_pic_size_o, inbuf_mode_o); end
        @(posedge clk_i);
        #1;
        idle_inputs();
        rst_n_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0 || cmd_level_o !== 3'd0) begin
            errors++; $display("FAIL areset release got busy=%0b level=%0d exp 0/0", busy_o, cmd_level_o); end
        do_push(10'h0D0, 8'd2, 4'd1, 1'b0, 16'd2);
        run_job(2, 1'b0, 0, 1'b0, 0);
        checks++; if (r_din !== 4 || r_dout !== 2 || r_done !== 1 || r_sop_hs !== 1) begin
            errors++; $display("FAIL areset new_job got din=%0d dout=%0d done=%0d sop=%0d exp 4/2/1/1", r_din, r_dout, r_done, r_sop_hs); end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_back_pressure();
        test_fifo();
        test_illegal_push();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
